// File: rtl/axi_lite_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// axi_lite_pkg : shared AXI4-Lite response codes, master FSM states, PROT value
// Revision     : 1.0
// ============================================================================
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } master_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// axi_lite_master_ctrl : single-outstanding AXI4-Lite initiator, cmd/rsp front end
// Revision             : 1.0
// ============================================================================
module axi_lite_master_ctrl
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int STRB_WIDTH     = AXI_DATA_WIDTH / 8
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0]     cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0]     M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  master_state_t               state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]       wstrb_q, wstrb_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  resp_t                       resp_q, resp_d;
  logic                        rsp_we_q, rsp_we_d;
  logic                        aw_now, w_now;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      rsp_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      rsp_we_q  <= rsp_we_d;
    end
  end

  // A channel counts as done once its handshake happened now or on an earlier cycle.
  assign aw_now = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_now  = w_done_q  | (M_AXI_WVALID  & M_AXI_WREADY);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    rsp_we_d  = rsp_we_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_we ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d   = resp_t'(M_AXI_BRESP);
          rdata_d  = '0;
          rsp_we_d = 1'b1;
          state_d  = RSP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          resp_d   = resp_t'(M_AXI_RRESP);
          rdata_d  = M_AXI_RDATA;
          rsp_we_d = 1'b0;
          state_d  = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every VALID/READY is decoded from registered state only.
  assign cmd_ready     = (state_q == IDLE);
  assign M_AXI_AWVALID = (state_q == WR_REQ) & ~aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR_REQ) & ~w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = (state_q == RD_REQ);
  assign M_AXI_RREADY  = (state_q == RD_DATA);
  assign rsp_valid     = (state_q == RSP);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;

  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule : axi_lite_master_ctrl
`default_nettype wire

// File: tb/tb_axi_lite_master_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_axi_lite_master_ctrl : bench with AXI-Lite responder and word-level memory model
// Revision                : 1.0
// ============================================================================
module tb_axi_lite_master_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [31:0] M_AXI_RDATA = '0;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;

  axi_lite_master_ctrl #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int n_wr = 0, n_rd = 0, b_count = 0, r_count = 0;
  int bready_viol = 0, cmdrdy_viol = 0, stab_viol = 0;
  bit [31:0] smem [0:63];
  bit [31:0] ref_mem [0:63];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map of the responder: 0x10-0x1F slave error, above 0xFF decode error.
  function automatic logic [1:0] addr_resp(input logic [31:0] a);
    if (a[31:8] != 0)     return 2'b11;
    if (a[7:4] == 4'h1)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Write-side responder
  initial begin : wr_slave
    bit aw_hs, w_hs, b_hs, have_aw, have_w;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    int aw_cnt, w_cnt, b_cnt;
    have_aw = 0; have_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs  = M_AXI_WVALID && M_AXI_WREADY;
      b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      if (aw_hs) s_awaddr = M_AXI_AWADDR;
      if (w_hs) begin s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; end
      @(posedge clk); #1;
      if (rst) begin
        have_aw = 0; have_w = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
      end else begin
        if (aw_hs) have_aw = 1;
        if (w_hs)  have_w  = 1;
        if (b_hs) begin M_AXI_BVALID = 0; M_AXI_BRESP = 2'($urandom); end
        if (!M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_dly == 0); aw_cnt = aw_dly; end
        else if (!M_AXI_AWREADY) begin
          if (aw_cnt > 0) aw_cnt--;
          if (aw_cnt == 0) M_AXI_AWREADY = 1;
        end
        if (!M_AXI_WVALID) begin M_AXI_WREADY = (w_dly == 0); w_cnt = w_dly; end
        else if (!M_AXI_WREADY) begin
          if (w_cnt > 0) w_cnt--;
          if (w_cnt == 0) M_AXI_WREADY = 1;
        end
        if (have_aw && have_w && !M_AXI_BVALID) begin
          if (b_cnt > 0) b_cnt--;
          else begin
            M_AXI_BRESP = addr_resp(s_awaddr);
            if (M_AXI_BRESP == 2'b00)
              for (int i = 0; i < 4; i++)
                if (s_wstrb[i]) smem[s_awaddr[7:2]][8*i +: 8] = s_wdata[8*i +: 8];
            M_AXI_BVALID = 1; have_aw = 0; have_w = 0;
          end
        end else if (!(have_aw && have_w)) b_cnt = b_dly;
      end
    end
  end

  // Read-side responder; data/resp are scrambled once the beat is consumed.
  initial begin : rd_slave
    bit ar_hs, r_hs, have_ar;
    logic [31:0] s_araddr;
    int ar_cnt, r_cnt;
    have_ar = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      if (ar_hs) s_araddr = M_AXI_ARADDR;
      @(posedge clk); #1;
      if (rst) begin
        have_ar = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
      end else begin
        if (ar_hs) have_ar = 1;
        if (r_hs) begin M_AXI_RVALID = 0; M_AXI_RDATA = $urandom; M_AXI_RRESP = 2'($urandom); end
        if (!M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_dly == 0); ar_cnt = ar_dly; end
        else if (!M_AXI_ARREADY) begin
          if (ar_cnt > 0) ar_cnt--;
          if (ar_cnt == 0) M_AXI_ARREADY = 1;
        end
        if (have_ar && !M_AXI_RVALID) begin
          if (r_cnt > 0) r_cnt--;
          else begin
            M_AXI_RRESP  = addr_resp(s_araddr);
            M_AXI_RDATA  = (M_AXI_RRESP == 2'b00) ? smem[s_araddr[7:2]] : 32'h0;
            M_AXI_RVALID = 1; have_ar = 0;
          end
        end else if (!have_ar) r_cnt = r_dly;
      end
    end
  end

  // Protocol monitor: write ordering, cmd_ready while busy, payload stability.
  initial begin : monitor
    bit mon_aw, mon_w, busy, pv_aw, pv_w, pv_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    mon_aw = 0; mon_w = 0; busy = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_aw = 0; mon_w = 0; busy = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
      end else begin
        if (M_AXI_BREADY && !(mon_aw && mon_w)) bready_viol++;
        if (busy && cmd_ready) cmdrdy_viol++;
        if (pv_aw && !(M_AXI_AWVALID && M_AXI_AWADDR == p_awaddr)) stab_viol++;
        if (pv_w && !(M_AXI_WVALID && M_AXI_WDATA == p_wdata && M_AXI_WSTRB == p_wstrb)) stab_viol++;
        if (pv_ar && !(M_AXI_ARVALID && M_AXI_ARADDR == p_araddr)) stab_viol++;
        if (M_AXI_AWVALID && M_AXI_AWREADY) mon_aw = 1;
        if (M_AXI_WVALID && M_AXI_WREADY)   mon_w  = 1;
        if (M_AXI_BVALID && M_AXI_BREADY) begin b_count++; mon_aw = 0; mon_w = 0; end
        if (M_AXI_RVALID && M_AXI_RREADY) r_count++;
        if (cmd_valid && cmd_ready) busy = 1;
        if (rsp_valid && rsp_ready) busy = 0;
        pv_aw = M_AXI_AWVALID && !M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
        pv_w  = M_AXI_WVALID && !M_AXI_WREADY;   p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
        pv_ar = M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic set_delays(input int aw, input int w, input int ar, input int b, input int r);
    aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    @(posedge clk); #1;
  endtask

  // One command end to end; expected response comes from the word-level memory model.
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int stall, input int exp_lat);
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int n;
    bit acc, got;
    e_resp = addr_resp(addr);
    if (we) begin
      e_rdata = 32'h0;
      if (e_resp == 2'b00)
        ref_mem[addr[7:2]] = (ref_mem[addr[7:2]] & ~strb_mask(strb)) | (wdata & strb_mask(strb));
      n_wr++;
    end else begin
      e_rdata = (e_resp == 2'b00) ? ref_mem[addr[7:2]] : 32'h0;
      n_rd++;
    end
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    rsp_ready = (stall == 0);
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1; n++;
    end
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    chk("cmd_accept", acc, 1);
    n = 1; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else begin @(posedge clk); #1; n++; end
    end
    chk("rsp_arrive", got, 1);
    if (exp_lat > 0) chk("latency", n, exp_lat);
    chk("rsp_we", rsp_we, we);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_resp", rsp_resp, e_resp);
    if (stall > 0) begin
      @(posedge clk); #1;
      cmd_valid = 1; cmd_we = 0;
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_rdata", rsp_rdata, e_rdata);
        chk("stall_no_ar", M_AXI_ARVALID, 0);
        chk("stall_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
      end
      cmd_valid = 0; rsp_ready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_released", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin : main
    logic [31:0] pat [4];
    logic [31:0] a;
    int bc;
    pat[0] = 32'hDEADBEEF; pat[1] = 32'hBAADF00D; pat[2] = 32'hFEEDFACE; pat[3] = 32'h0BADC0DE;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", M_AXI_AWVALID, 0);
    chk("rst_wvalid", M_AXI_WVALID, 0);
    chk("rst_arvalid", M_AXI_ARVALID, 0);
    chk("rst_bready", M_AXI_BREADY, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_awaddr", M_AXI_AWADDR, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("awprot", M_AXI_AWPROT, 0);
    chk("arprot", M_AXI_ARPROT, 0);

    // Always-ready responder: best-case latency.
    set_delays(0, 0, 0, 0, 0);
    run_cmd(1, 32'h0, 32'hDEADBEEF, 4'hF, 0, 3);
    run_cmd(0, 32'h0, 32'h0, 4'h0, 0, 3);

    set_delays(2, 1, 3, 2, 1);
    for (int i = 0; i < 4; i++) run_cmd(1, 32'(4 * i), pat[i], 4'hF, 0, -1);
    for (int i = 0; i < 4; i++) run_cmd(0, 32'(4 * i), 32'h0, 4'h0, 0, -1);

    // AW well ahead of W, then the reverse.
    set_delays(1, 4, 0, 0, 0);
    bc = b_count;
    run_cmd(1, 32'h20, 32'h11223344, 4'hF, 0, -1);
    chk("single_b_aw_first", b_count - bc, 1);
    set_delays(4, 1, 0, 0, 0);
    bc = b_count;
    run_cmd(1, 32'h24, 32'h55667788, 4'b0101, 0, -1);
    chk("single_b_w_first", b_count - bc, 1);
    run_cmd(0, 32'h20, 32'h0, 4'h0, 0, -1);
    run_cmd(0, 32'h24, 32'h0, 4'h0, 0, -1);

    // Error responses pass through and do not disturb the next command.
    set_delays(0, 0, 1, 0, 1);
    run_cmd(0, 32'h10, 32'h0, 4'h0, 0, -1);
    run_cmd(1, 32'h14, 32'hA5A5A5A5, 4'hF, 0, -1);
    run_cmd(0, 32'h1000, 32'h0, 4'h0, 0, -1);
    run_cmd(0, 32'h4, 32'h0, 4'h0, 0, -1);

    run_cmd(0, 32'h8, 32'h0, 4'h0, 5, -1);

    // Reset while the write request is still pending.
    set_delays(5, 5, 0, 0, 0);
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h30; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    @(negedge clk);
    chk("pre_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    chk("wr_req_awvalid", M_AXI_AWVALID, 1);
    chk("wr_req_wvalid", M_AXI_WVALID, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_awvalid", M_AXI_AWVALID, 0);
    chk("rst_mid_wvalid", M_AXI_WVALID, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    set_delays(0, 0, 0, 0, 0);
    run_cmd(1, 32'h30, 32'hCAFEF00D, 4'hF, 0, 3);
    run_cmd(0, 32'h30, 32'h0, 4'h0, 0, 3);

    for (int i = 0; i < 40; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)),
              ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, -1);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("bready_after_both", bready_viol, 0);
    chk("cmd_ready_low_busy", cmdrdy_viol, 0);
    chk("payload_stable", stab_viol, 0);
    chk("b_response_count", b_count, n_wr);
    chk("r_response_count", r_count, n_rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axi_lite_master_ctrl
`default_nettype wire

// File: doc/axi_lite_master_ctrl.md
Name: axi_lite_master_ctrl

Overview:
Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI-Lite write and read transactions. It is the RTL counterpart of the verification master agent. It drives axi_lite_template_slave and any other AXI-Lite slave in the design from internal control logic such as sequencers or CPU-less config engines.

Parameters:
AXI_ADDR_WIDTH, 32, width of AWADDR/ARADDR and cmd_addr
AXI_DATA_WIDTH, 32, width of WDATA/RDATA; must be 32 or 64
STRB_WIDTH, AXI_DATA_WIDTH/8, width of WSTRB and cmd_wstrb (derived; do not override)

Ports:
M_AXI_ACLK  in  1  single clock, rising-edge
M_AXI_ARESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts command (high only in IDLE)
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  AXI_ADDR_WIDTH  byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data
cmd_wstrb  in  STRB_WIDTH  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_we  out  1  echo of cmd_we for this response
rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP
M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1  write address channel; AWPROT fixed 3'b000
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  DATA/STRB/1  write data channel
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1  write response
M_AXI_BREADY  out  1
M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1  read address; ARPROT fixed 3'b000
M_AXI_ARREADY  in  1
M_AXI_RDATA/RRESP/RVALID  in  DATA/2/1  read data
M_AXI_RREADY  out  1

Behaviour:
- Interface decided: one clock; reset is synchronous and active-high. Clock M_AXI_ACLK, reset M_AXI_ARESET.
- Reset values: all *VALID, BREADY, RREADY, rsp_valid = 0; cmd_ready = 1 after reset release; addr/data/rsp regs = 0; FSM = IDLE.
- Reset mid-transaction: FSM returns to IDLE on the same edge and the transaction is dropped. System-level reset of the slave is required alongside.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, register addr/data/strb/we. Go to WR_REQ (assert AWVALID and WVALID next cycle) or RD_REQ (assert ARVALID next cycle).
- WR_REQ: AWVALID and WVALID rise together. Each drops independently on the cycle after its own VALID & READY. Both handshakes may complete in the same cycle, in either order, or in different cycles. Exit to WR_RESP only when both are done.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set rsp_rdata = 0 and rsp_we = 1, drop BREADY, go to RSP.
- RD_REQ: ARVALID held with stable ARADDR until ARREADY, then drop and go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA/RRESP, drop RREADY, go to RSP.
- RSP: rsp_valid = 1 with rsp_* stable until rsp_ready. Go to IDLE on the next edge, so cmd_ready reasserts one cycle after the response handshake.
- VALID signals never depend combinationally on READY. Payload is stable while VALID is high.
- Best-case latency with ready slaves: cmd accept -> rsp_valid in 3 cycles for a read and 3 cycles for a write.
- SLVERR and DECERR are passed through in rsp_resp and are not retried.

Decomposition:
- Package axi_lite_pkg: resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), master_state_t enum, PROT_DEFAULT constant.
- No sub-module needed. The AW/W "done" flags live in the single FSM module.

Test Plan:
- Write cmd addr 0x0, data 0xDEADBEEF, strb 4'b1111 to axi_lite_template_slave, then read 0x0 -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_we=0.
- Four writes (0xDEADBEEF, 0xBAADF00D, 0xFEEDFACE, 0x0BADC0DE at 0x0/0x4/0x8/0xC), then four reads -> all match, and cmd_ready stays low throughout each transaction.
- Responder model with AWREADY 3 cycles before WREADY and then the reverse order -> BREADY asserts only after both handshakes; single B response.
- Responder returns RRESP=2'b10 on read of 0x10 -> rsp_resp=2'b10; next command accepted normally.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable; no new AR issued even with cmd_valid high.
- Assert M_AXI_ARESET while in WR_REQ -> next edge AWVALID=WVALID=0, cmd_ready=1 after release, and the following write completes correctly.
